// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one byte to the device with the request-to-send sequence (clock
// inhibit, start-bit request, device-clocked data/parity/stop) and checks
// the device ACK. Only open-collector pull-down enables are produced; the
// top level ties each pin low when its enable is 1, else 'z'.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   tx_data, tx_valid       command byte and send request
//   tx_ready                high only while idle; accept = tx_valid && tx_ready
//   ps2_clk_i, ps2_data_i   raw pin values (synchronised internally)
//   ps2_clk_oe, ps2_data_oe 1 = pull the corresponding line low
//   busy                    high from accept until the terminal pulse
//   done                    pulse: byte ACKed and bus idle
//   ack_err                 pulse: data high at the ACK edge
//   timeout_err             pulse: start or bit timeout

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int SETUP_CYCLES         = 250,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAX_B = (START_TIMEOUT_CYCLES > BIT_TIMEOUT_CYCLES) ?
                           START_TIMEOUT_CYCLES : BIT_TIMEOUT_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] START_LIM  = CW'(START_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] BIT_LIM    = CW'(BIT_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc, limit;
    logic [3:0]    bit_cnt, bit_cnt_n, edge_num;
    logic [7:0]    tx_byte, tx_byte_n;
    logic          parity, parity_n;
    logic          ack_ok, ack_ok_n;
    logic          data_oe_q, data_oe_n;
    logic          clk_s1, clk_s2, clk_prev;
    logic          data_s1, data_s2;
    logic          dev_fall;

    // Synchronisers reset to 1 (idle bus) so no false edge follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_i;
            data_s2  <= data_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_byte   <= '0;
            parity    <= 1'b0;
            ack_ok    <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            tx_byte   <= tx_byte_n;
            parity    <= parity_n;
            ack_ok    <= ack_ok_n;
            data_oe_q <= data_oe_n;
        end
    end

    assign dev_fall = clk_prev & ~clk_s2;
    assign edge_num = bit_cnt + 4'd1;
    assign cnt_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt_inc;
        bit_cnt_n   = bit_cnt;
        tx_byte_n   = tx_byte;
        parity_n    = parity;
        ack_ok_n    = ack_ok;
        data_oe_n   = data_oe_q;
        ps2_clk_oe  = 1'b0;
        done        = 1'b0;
        ack_err     = 1'b0;
        timeout_err = 1'b0;
        // The first device edge may take much longer than later ones.
        limit       = (bit_cnt == 4'd0) ? START_LIM : BIT_LIM;

        case (state)
            S_IDLE: begin
                cnt_n     = '0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    tx_byte_n = tx_data;
                    parity_n  = ~^tx_data;
                    bit_cnt_n = '0;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                data_oe_n  = 1'b0;
                if (cnt == INH_LAST) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = S_REQ;
                end
            end
            S_REQ: begin
                ps2_clk_oe = 1'b1;
                if (cnt == SETUP_LAST) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (dev_fall) begin
                    cnt_n     = '0;
                    bit_cnt_n = edge_num;
                    if (edge_num <= 4'd8) begin
                        data_oe_n = ~tx_byte[bit_cnt[2:0]];
                    end else if (edge_num == 4'd9) begin
                        data_oe_n = ~parity;
                    end else if (edge_num == 4'd10) begin
                        data_oe_n = 1'b0;
                    end else begin
                        ack_ok_n  = ~data_s2;
                        data_oe_n = 1'b0;
                        state_n   = S_WAIT_IDLE;
                    end
                end else if (cnt >= limit) begin
                    timeout_err = 1'b1;
                    data_oe_n   = 1'b0;
                    cnt_n       = '0;
                    state_n     = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                data_oe_n = 1'b0;
                if (clk_s2 && data_s2) begin
                    done    = ack_ok;
                    ack_err = ~ack_ok;
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else if (cnt >= BIT_LIM) begin
                    timeout_err = 1'b1;
                    cnt_n       = '0;
                    state_n     = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Release data in the very cycle a timeout is reported.
    assign ps2_data_oe = data_oe_q & ~timeout_err;
    assign tx_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE) & ~(done | ack_err | timeout_err);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

    localparam int INH   = 40;
    localparam int SETUP = 8;
    localparam int START = 300;
    localparam int BITTO = 150;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_err, timeout_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;

    // Wired-AND open-collector bus.
    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .SETUP_CYCLES        (SETUP),
        .START_TIMEOUT_CYCLES(START),
        .BIT_TIMEOUT_CYCLES  (BITTO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int n_done, n_ackerr, n_to, n_inh, n_req, n_entry;
    int t_to, t_oe_fall, t_dev_fall;
    logic prev_clk_oe = 1'b0;
    logic prev_clk_i  = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (done)        n_done++;
            if (ack_err)     n_ackerr++;
            if (timeout_err) begin n_to++; t_to = cyc; end
            if (ps2_clk_oe && !ps2_data_oe) n_inh++;
            if (ps2_clk_oe && ps2_data_oe)  n_req++;
            if (ps2_clk_oe && !prev_clk_oe) n_entry++;
            if (!ps2_clk_oe && prev_clk_oe) t_oe_fall = cyc;
            if (!ps2_clk_i && prev_clk_i && !ps2_clk_oe) t_dev_fall = cyc;
        end
        prev_clk_oe = ps2_clk_oe;
        prev_clk_i  = ps2_clk_i;
    end

    task automatic clear_mon();
        n_done = 0; n_ackerr = 0; n_to = 0; n_inh = 0; n_req = 0; n_entry = 0;
        t_to = 0; t_oe_fall = 0; t_dev_fall = 0;
    endtask

    // Reference frame as the device sees it: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = 1'((b >> i) & 8'd1);
        f[8] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic accept(input logic [7:0] b, input logic [7:0] after, input bit hold);
        @(posedge clk); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = after;
        if (!hold) tx_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_state: busy=%b tx_ready=%b expected busy=1 tx_ready=0", busy, tx_ready);
        end
    endtask

    // Device: wait for request, clock n_edges falling edges, read bits on the high phase.
    task automatic dev_frame(input int n_edges, input bit do_ack, output logic [9:0] seen, output bit ok);
        ok = 1'b0;
        seen = '0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (ps2_clk_i && !ps2_data_i && !ps2_clk_oe) begin ok = 1'b1; break; end
        end
        if (ok) begin
            for (int e = 1; e <= n_edges; e++) begin
                if (e == 11 && do_ack) dev_data = 1'b0;
                repeat (HALF) @(posedge clk);
                #1 dev_clk = 1'b0;
                repeat (HALF) @(posedge clk);
                #1 dev_clk = 1'b1;
                repeat (HALF / 2) @(posedge clk);
                #1;
                if (e <= 10) seen[e-1] = ps2_data_i;
                if (e == 11) dev_data = 1'b1;
            end
        end
    endtask

    // Returns in the cycle after the target number of terminal pulses.
    task automatic wait_term(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #2;
            if (n_done + n_ackerr + n_to >= target) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_term: no terminal pulse within bound, got %0d expected %0d", n_done + n_ackerr + n_to, target);
        end
    endtask

    task automatic check_idle_after(input string name);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: ready=%b busy=%b clk_oe=%b data_oe=%b expected 1 0 0 0",
                     name, tx_ready, busy, ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b clk_oe=%b data_oe=%b expected 1 0 0 0",
                     tx_ready, busy, ps2_clk_oe, ps2_data_oe);
        end
        checks++;
        if (done !== 1'b0 || ack_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: done=%b ack_err=%b timeout_err=%b expected 0 0 0", done, ack_err, timeout_err);
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_send(input logic [7:0] b, input string name);
        logic [9:0] seen;
        bit ok, tok;
        clear_mon();
        accept(b, b, 1'b0);
        dev_frame(11, 1'b1, seen, ok);
        checks++;
        if (!ok || seen !== frame_of(b)) begin
            errors++;
            $display("FAIL %s_bits: got %b expected %b (req_seen=%0d)", name, seen, frame_of(b), ok);
        end
        wait_term(1, tok);
        check_idle_after(name);
        checks++;
        if (n_done !== 1 || n_ackerr !== 0 || n_to !== 0) begin
            errors++;
            $display("FAIL %s_pulses: done=%0d ack_err=%0d to=%0d expected 1 0 0", name, n_done, n_ackerr, n_to);
        end
        checks++;
        if (n_inh !== INH || n_req !== SETUP) begin
            errors++;
            $display("FAIL %s_timing: inhibit=%0d req=%0d expected %0d %0d", name, n_inh, n_req, INH, SETUP);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) test_send(8'($urandom), "random");
    endtask

    task automatic test_ack_err();
        logic [9:0] seen;
        bit ok, tok;
        logic [7:0] b;
        b = 8'($urandom);
        clear_mon();
        accept(b, b, 1'b0);
        dev_frame(11, 1'b0, seen, ok);
        checks++;
        if (!ok || seen !== frame_of(b)) begin
            errors++;
            $display("FAIL ackerr_bits: got %b expected %b", seen, frame_of(b));
        end
        wait_term(1, tok);
        repeat (5) @(posedge clk);
        #2;
        check_idle_after("ackerr");
        checks++;
        if (n_ackerr !== 1 || n_done !== 0 || n_to !== 0) begin
            errors++;
            $display("FAIL ackerr_pulses: ack_err=%0d done=%0d to=%0d expected 1 0 0", n_ackerr, n_done, n_to);
        end
    endtask

    task automatic test_start_timeout();
        bit tok;
        clear_mon();
        accept(8'hF4, 8'hF4, 1'b0);
        wait_term(1, tok);
        check_idle_after("start_to");
        checks++;
        if (n_to !== 1 || n_done !== 0 || n_ackerr !== 0 || (t_to - t_oe_fall) !== START) begin
            errors++;
            $display("FAIL start_timeout: to=%0d delay=%0d expected to=1 delay=%0d", n_to, t_to - t_oe_fall, START);
        end
    endtask

    task automatic test_bit_timeout();
        logic [9:0] seen;
        bit ok, tok;
        clear_mon();
        accept(8'h5A, 8'h5A, 1'b0);
        dev_frame(4, 1'b0, seen, ok);
        wait_term(1, tok);
        check_idle_after("bit_to");
        // pin fall -> edge acted on 3 clk later -> then BITTO cycles
        checks++;
        if (!ok || n_to !== 1 || n_done !== 0 || (t_to - t_dev_fall) !== BITTO + 3) begin
            errors++;
            $display("FAIL bit_timeout: to=%0d delay=%0d expected to=1 delay=%0d", n_to, t_to - t_dev_fall, BITTO + 3);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] seen;
        bit ok;
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;
        clear_mon();
        accept(b, b, 1'b0);
        dev_frame(4, 1'b0, seen, ok);
        checks++;
        if (!ok || ps2_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: data_oe=%b expected 1", ps2_data_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: clk_oe=%b data_oe=%b busy=%b expected 0 0 0", ps2_clk_oe, ps2_data_oe, busy);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (BITTO + 20) @(posedge clk);
        #2;
        check_idle_after("rstmid");
        checks++;
        if (n_done !== 0 || n_ackerr !== 0 || n_to !== 0) begin
            errors++;
            $display("FAIL rstmid_pulses: done=%0d ack_err=%0d to=%0d expected 0 0 0", n_done, n_ackerr, n_to);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] seen;
        bit ok, tok, started;
        logic [7:0] b;
        b = 8'($urandom) & 8'h7F;
        clear_mon();
        accept(b, 8'hFF, 1'b1);
        dev_frame(11, 1'b1, seen, ok);
        checks++;
        if (!ok || seen !== frame_of(b)) begin
            errors++;
            $display("FAIL b2b_first_bits: got %b expected %b", seen, frame_of(b));
        end
        wait_term(1, tok);
        checks++;
        if (tx_ready !== 1'b1 || n_entry !== 1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b inhibits=%0d expected 1 1", tx_ready, n_entry);
        end
        started = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ps2_clk_oe) begin started = 1'b1; break; end
        end
        tx_valid = 1'b0;
        dev_frame(11, 1'b1, seen, ok);
        checks++;
        if (!started || !ok || seen !== frame_of(8'hFF)) begin
            errors++;
            $display("FAIL b2b_second_bits: got %b expected %b started=%0d", seen, frame_of(8'hFF), started);
        end
        wait_term(2, tok);
        repeat (INH) @(posedge clk);
        #2;
        check_idle_after("b2b");
        checks++;
        if (n_done !== 2 || n_entry !== 2 || n_inh !== 2 * INH || n_ackerr !== 0 || n_to !== 0) begin
            errors++;
            $display("FAIL b2b_counts: done=%0d inhibits=%0d inh_cycles=%0d expected 2 2 %0d",
                     n_done, n_entry, n_inh, 2 * INH);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_send(8'hED, "send_ED");
        test_send(8'hF4, "send_F4");
        test_send(8'h00, "send_00");
        test_random();
        test_ack_err();
        test_start_timeout();
        test_bit_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the send direction complementing the keyboard receive path.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) using the PS/2 request-to-send sequence, then checks the device ACK.
- Drives open-collector enables only. The top level ties each pin low when its enable is 1, else 'z'.
- `busy` lets the top gate the keyboard receiver during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low hold before request (100 us @ 50 MHz).
- SETUP_CYCLES, 250: data-low overlap with clock still held low (5 us).
- START_TIMEOUT_CYCLES, 750000: max wait from clock release to first device falling edge (15 ms).
- BIT_TIMEOUT_CYCLES, 100000: max gap between device falling edges, and max wait for idle after ACK (2 ms).

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid && tx_ready
- ps2_clk_i  in  1  raw PS2_CLK pin value
- ps2_data_i  in  1  raw PS2_DATA pin value
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low
- busy  out  1  high from accept until completion or error
- done  out  1  one-cycle pulse: byte ACKed and bus idle
- ack_err  out  1  one-cycle pulse: data high at ACK edge
- timeout_err  out  1  one-cycle pulse: start or bit timeout

Behaviour:
- Reset (async): state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done/ack_err/timeout_err=0, tx_ready=1, counters=0. Reset mid-operation releases both lines immediately with no pulse.
- Inputs pass through 2-FF synchronisers. A device falling edge is sync'd prev=1, cur=0. Edge is acted on 3 clk after the pin falls.
- Accept: latch tx_data and parity = ~^tx_data (odd parity). Next cycle state=INHIBIT, busy=1, tx_ready=0. tx_valid while not ready is ignored.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles. Then REQ.
- REQ: clk_oe=1, data_oe=1 (start bit) for SETUP_CYCLES cycles. Then SHIFT with clk_oe=0 and data_oe held at 1. Clear bit counter and timeout counter.
- SHIFT: on each device falling edge, bit_cnt increments (1..11) and the timeout counter clears.
  - Edges 1-8: data_oe = ~tx_data[bit_cnt-1] (LSB first).
  - Edge 9: data_oe = ~parity.
  - Edge 10: data_oe=0 (stop bit, line released).
  - Edge 11: sample sync'd data. 0 → WAIT_IDLE with ack_ok=1. 1 → WAIT_IDLE with ack_ok=0.
- Timeouts in SHIFT:
  - Before edge 1: START_TIMEOUT_CYCLES applies.
  - After edge 1: BIT_TIMEOUT_CYCLES applies.
  - Expiry: clk_oe=data_oe=0, timeout_err pulse, busy=0, return to IDLE.
- WAIT_IDLE: wait for sync'd clk=1 and data=1 on the same cycle.
  - Then pulse done (ack_ok) or ack_err (!ack_ok). busy=0 on that cycle; IDLE next cycle.
  - If BIT_TIMEOUT_CYCLES expires first, pulse timeout_err instead.
- Only one of done/ack_err/timeout_err ever pulses per byte.
- Entering INHIBIT while the device is mid-frame is legal: the inhibit aborts the device frame.
- Counters are sized with $clog2 of the largest parameter +1. Counters saturate and never wrap.
- Back-to-back sends: tx_ready is high the cycle after the terminal pulse. A new accept then restarts at INHIBIT.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs:
  - clk_oe=1 for 5000 cycles, then data_oe=1 for the 250-cycle overlap.
  - Bits seen by the device are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; tx_ready returns to 1.
- Send 0xF4 (five ones): parity bit 0; done. Send 0x00: all data bits 0, parity 1; done.
- Device leaves data high at edge 11: ack_err pulses once, no done, both oe=0 at the end.
- Device never clocks after REQ: timeout_err exactly START_TIMEOUT_CYCLES after clk_oe falls; both oe=0; tx_ready=1.
- Device stops after edge 4: timeout_err after BIT_TIMEOUT_CYCLES. Separately, assert rst_n=0 after edge 4: oe=0 immediately, no pulse, tx_ready=1 after release.
- tx_valid held high with 0xFF during an active send: ignored. The second byte starts only after done, with exactly one INHIBIT per byte.
